// File: rtl/rr_merge8_1_if.sv
// rr_merge8_1_if
// Bundles the eight producer channels and the single merged output channel
// of the round-robin 8:1 merge stage.
//   in_valid  [7:0]          bit k: producer k offers a beat
//   in_data   [8*WIDTH-1:0]  producer k data at [k*WIDTH +: WIDTH]
//   in_ready  [7:0]          bit k: producer k's beat is taken this cycle
//   out_valid                merged output register holds a beat
//   out_data  [WIDTH-1:0]    held beat data
//   out_sel   [2:0]          source channel of the held beat
//   out_ready                consumer accepts the held beat this cycle
// Modports: slave = the merge block, master = producers plus consumer.
interface rr_merge8_1_if #(
   parameter int WIDTH = 32
);
   logic [7:0]         in_valid;
   logic [8*WIDTH-1:0] in_data;
   logic [7:0]         in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [2:0]         out_sel;
   logic               out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_merge8_1.sv
// rr_merge8_1
// Round-robin 8-to-1 merge into one registered output channel. Each beat
// carries its source index on out_sel so a downstream 1:8 demux can route
// responses back.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    rr_merge8_1_if.slave (eight valid/ready inputs, one output)
// in_ready depends only on in_valid, out_valid, out_ready and the priority
// pointer; the out_ready -> in_ready combinational path is intentional so a
// consume and a load can happen in the same cycle.
module rr_merge8_1 #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   rr_merge8_1_if.slave bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [2:0]         ptr;
   logic [2:0]         grant;
   logic [WIDTH-1:0]   data_q;
   logic [2:0]         sel_q;
   logic [WIDTH-1:0]   grant_data;
   logic               load_ok;
   logic               load;
   logic [7:0]         ready;

   // First requesting channel scanning base, base+1, ... with 3-bit wrap.
   function automatic logic [2:0] pick(input logic [7:0] req,
                                       input logic [2:0] base);
      logic [2:0] idx;
      logic [2:0] g;
      logic       hit;
      g   = base;
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = base + 3'(i);
         if (!hit && req[idx]) begin
            g   = idx;
            hit = 1'b1;
         end
      end
      return g;
   endfunction

   assign grant = pick(bus.in_valid, ptr);

   // Mux selected by the grant only, so in_data never feeds in_ready.
   always_comb begin
      grant_data = '0;
      for (int k = 0; k < 8; k++) begin
         if (grant == 3'(k)) grant_data = bus.in_data[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_nx = state;
      load_ok  = (state == EMPTY) || bus.out_ready;
      load     = 1'b0;
      ready    = '0;
      case (state)
         EMPTY: begin
            if (|bus.in_valid) begin
               load     = 1'b1;
               state_nx = FULL;
            end
         end
         FULL: begin
            if (bus.out_ready) begin
               if (|bus.in_valid) begin
                  load     = 1'b1;
                  state_nx = FULL;
               end else begin
                  state_nx = EMPTY;
               end
            end
         end
         default: state_nx = EMPTY;
      endcase
      // Grants are suppressed for the whole cycle while reset is asserted.
      if (rst_n && load) ready = 8'b1 << grant;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nx;
   end

   // Output register and priority pointer; ptr wraps 7 -> 0 by truncation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
         sel_q  <= '0;
         ptr    <= '0;
      end else if (load) begin
         data_q <= grant_data;
         sel_q  <= grant;
         ptr    <= grant + 3'd1;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = (state == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_rr_merge8_1.sv
// tb_rr_merge8_1
// Directed bench for rr_merge8_1: reset, full rotation, sparse requests,
// backpressure, drain with pointer wrap, and reset during a stall.
module tb_rr_merge8_1;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   rr_merge8_1_if #(.WIDTH(32)) bus ();

   rr_merge8_1 #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int k, input logic [31:0] v);
      bus.in_data[k*32 +: 32] = v;
   endtask

   task automatic chk_out(input string tag, input logic v,
                          input logic [2:0] s, input logic [31:0] d);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
      chk({tag, "_sel"},   32'(bus.out_sel),   32'(s));
      chk({tag, "_data"},  bus.out_data,       d);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 8'hFF;
      bus.out_ready = 1'b1;
      bus.in_data   = '0;
      for (int k = 0; k < 8; k++) set_data(k, 32'hA0 + 32'(k));

      // Reset values held for two edges with every channel requesting.
      #1;
      chk("rst_ready_comb", 32'(bus.in_ready), 32'h0);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk_out("rst", 1'b0, 3'd0, 32'h0);
         chk("rst_ready", 32'(bus.in_ready), 32'h0);
      end

      // Release; full rotation 0..7,0,1.
      rst_n = 1'b1;
      #1;
      chk("rot_ready0", 32'(bus.in_ready), 32'h01);
      tick();
      chk_out("rot0", 1'b1, 3'd0, 32'hA0);
      for (int i = 1; i < 10; i++) begin
         chk("rot_ready", 32'(bus.in_ready), 32'(8'b1 << (i % 8)));
         tick();
         chk_out("rot", 1'b1, 3'(i % 8), 32'hA0 + 32'(i % 8));
      end

      // Sparse: restart from ptr=0, channels 2 and 6.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.in_valid = 8'h44;
      tick(); chk_out("sp_a", 1'b1, 3'd2, 32'hA2);
      tick(); chk_out("sp_b", 1'b1, 3'd6, 32'hA6);
      tick(); chk_out("sp_c", 1'b1, 3'd2, 32'hA2);
      tick(); chk_out("sp_d", 1'b1, 3'd6, 32'hA6);
      bus.in_valid = 8'h04;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("sp_only2", 1'b1, 3'd2, 32'hA2);
      end
      // ptr is now 3: with channels 2 and 3 both valid, channel 3 wins.
      bus.in_valid = 8'h0C;
      #1;
      chk("sp_ptr3_ready", 32'(bus.in_ready), 32'h08);
      tick(); chk_out("sp_ptr3", 1'b1, 3'd3, 32'hA3);

      // Empty the register, then backpressure on channel 5.
      bus.in_valid = 8'h00;
      tick(); chk("bp_empty", 32'(bus.out_valid), 32'h0);
      bus.out_ready = 1'b0;
      bus.in_valid  = 8'h20;
      set_data(5, 32'h55);
      #1;
      chk("bp_load_ready", 32'(bus.in_ready), 32'h20);
      tick();
      set_data(5, 32'h66);
      for (int i = 0; i < 4; i++) begin
         chk("bp_stall_ready", 32'(bus.in_ready), 32'h0);
         chk_out("bp_hold", 1'b1, 3'd5, 32'h55);
         tick();
      end
      chk_out("bp_hold_end", 1'b1, 3'd5, 32'h55);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.in_ready), 32'h20);
      tick(); chk_out("bp_nobubble", 1'b1, 3'd5, 32'h66);

      // Drain: one beat from channel 7, then nothing.
      bus.in_valid = 8'h80;
      set_data(7, 32'h77);
      tick(); chk_out("dr_beat", 1'b1, 3'd7, 32'h77);
      bus.in_valid = 8'h00;
      tick(); chk_out("dr_empty1", 1'b0, 3'd7, 32'h77);
      tick(); chk_out("dr_empty2", 1'b0, 3'd7, 32'h77);
      // ptr wrapped to 0, so channel 0 beats channel 4.
      bus.in_valid = 8'h11;
      #1;
      chk("dr_wrap_ready", 32'(bus.in_ready), 32'h01);
      tick(); chk_out("dr_wrap", 1'b1, 3'd0, 32'hA0);

      // Reset while FULL and stalled; ptr is 1 going in.
      bus.out_ready = 1'b0;
      bus.in_valid  = 8'h10;
      tick(); chk_out("rs_stall", 1'b1, 3'd0, 32'hA0);
      rst_n = 1'b0;
      #1;
      chk("rs_ready_low", 32'(bus.in_ready), 32'h0);
      tick(); chk_out("rs_after", 1'b0, 3'd0, 32'h0);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 8'h03;
      #1;
      chk("rs_ptr0_ready", 32'(bus.in_ready), 32'h01);
      tick(); chk_out("rs_ptr0", 1'b1, 3'd0, 32'hA0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_merge8_1.md
# rr_merge8_1

Round-robin 8-to-1 merge stage: the gather counterpart of the 1:8 demultiplexer used for register write-enable and result distribution. Eight independent valid/ready producer channels compete for one registered output channel. Each transferred beat carries its source index on `out_sel`, which is in the same encoding as the demultiplexer's `sel`, so a downstream demux can route responses back. The block sits between the per-unit result sources and the shared writeback/bus path.

## Interface
- `WIDTH`, 32, data width of every channel.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous, active-low reset, sampled on `clk`.
- `in_valid`  input  8  bit k: channel k offers a beat.
- `in_data`  input  8*WIDTH  channel k data at `[k*WIDTH +: WIDTH]`.
- `in_ready`  output  8  bit k: channel k's beat is taken this cycle. At most one bit is high.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  WIDTH  held beat data.
- `out_sel`  output  3  source channel index of the held beat (0..7).
- `out_ready`  input  1  consumer accepts the held beat this cycle.

## Operation
- Transfer rules:
  - An input transfer on channel k occurs when `in_valid[k] && in_ready[k]` at a rising edge.
  - An output transfer occurs when `out_valid && out_ready`.
- Output register states:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- `load_ok = !out_valid || out_ready`. The register can accept a new beat this cycle.
- Priority pointer `ptr` is a 3-bit register.
  - Arbitration scans channels in the order ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
  - Grant `g` is the first channel in that order with `in_valid` high.
- `in_ready = load_ok && any(in_valid) ? onehot(g) : 8'b0`.
  - This is combinational from `in_valid`, `out_valid`, `out_ready` and `ptr`.
  - It must never depend on `in_data`.
- On an edge with `load_ok` and any valid input:
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= g+1`. This wraps 7→0 by 3-bit truncation.
- On an edge with `load_ok` and no valid input:
  - `out_valid <= 0`.
  - `out_data` and `out_sel` hold their last values.
  - `ptr` is unchanged.
- On an edge with `!load_ok` (FULL and stalled):
  - All registers hold.
  - `out_data` and `out_sel` stay stable while `out_valid`=1 and `out_ready`=0.
- State transitions:
  - EMPTY→FULL on load.
  - FULL→FULL on simultaneous consume+load, or on stall.
  - FULL→EMPTY on consume with no valid input.
- There is no lock before a grant. A channel may drop `in_valid` before being granted with no side effect.
  - The block does not require inputs to hold valid. Producers are expected to follow valid/ready rules.
- Fairness: with all 8 channels continuously valid and `out_ready`=1, each channel is served exactly once per 8 consecutive transfers.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0.
  - `in_ready`=0 for the whole cycle while `rst_n` is low, regardless of `load_ok`.
- Latency: an input beat granted at edge N appears on `out_*` after edge N (1 cycle).
- Throughput: 1 beat per cycle when `out_ready` is held high.
- Simultaneous consume and load in the same cycle is required. There is no bubble.
- Reset mid-operation: a held beat is discarded and `out_valid` falls after the reset edge. Grants in progress are cancelled because `in_ready` is forced to 0.
- `out_ready` may toggle while `out_valid`=0. It has no effect then, except that `load_ok` is already 1.
- Combinational path `out_ready`→`in_ready` is allowed and documented. There is no path from `in_valid` to `out_valid` within one cycle.

## Test plan
- **Reset values.** Drive `rst_n`=0 with `in_valid`=8'hFF and `out_ready`=1 for 2 cycles.
  - `out_valid`=0, `out_sel`=0, `out_data`=0, `in_ready`=0.
  - After release: first grant is channel 0 and `out_sel`=0 one cycle later.
- **Full rotation.** `in_valid`=8'hFF held, channel k data = 32'hA0+k, `out_ready`=1.
  - `out_sel` sequence is 0,1,…,7,0,1.
  - `out_data` = 32'hA0..32'hA7, then wraps to 32'hA0.
  - `in_ready` is one-hot each cycle.
- **Sparse requests.** Only channels 2 and 6 valid, `ptr` starting at 0.
  - Grants alternate 2,6,2,6.
  - Then drop ch6: grants 2,2,2.
  - `ptr` after each ch2 grant is 3.
- **Backpressure.** `out_ready`=0 for 4 cycles with ch5 valid and data 32'h55.
  - Loaded once, then `out_valid`=1 with `out_sel`=5 and `out_data`=32'h55 stable.
  - `in_ready`=0 for all 4 cycles.
  - On `out_ready`=1 the next beat is loaded in the same cycle (no bubble).
- **Drain.** Single beat on ch7, then `in_valid`=0, with `out_ready`=1.
  - `out_valid` is 1 for exactly one cycle, then 0.
  - `out_sel` holds 7.
  - The next grant after ch4 and ch0 become valid is channel 0, because `ptr` wrapped 7→0.
- **Reset mid-stall.** FULL with `out_ready`=0, assert `rst_n`=0 for one edge.
  - `out_valid`=0 and `ptr`=0 after that edge.
  - The held beat is never transferred.
